control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  7-step stepper plus instruction decoder for the 8-bit CPU. Drives every register set/enable,
//  bus1 and alu_op. Steps 1-3 fetch into the IR; steps 4-6 execute from the IR contents; step 7 is idle.
//  Sits between the IR/flags registers and the register/ALU/RAM datapath.
// PARAMETERS
//  HALT_ON_IO  0  1: opcode 0111 (IO) halts the sequencer after step 7; 0: IO executes as a no-op
// PORTS
//  clk       in   1  system clock; all state changes on rising edge
//  reset_n   in   1  asynchronous, active-low reset
//  run       in   1  1 = keep fetching; sampled in IDLE and at the end of step 7
//  ir        in   8  instruction from the IR register output
//  flags_in  in   4  {C,A,E,Z} from the flags register
//  step      out  7  one-hot current step (bit0 = step 1); 0 in IDLE
//  halted    out  1  1 while in IDLE
//  ir_s, iar_e, iar_s, mar_s, ram_e, ram_s, acc_e, acc_s, tmp_s, flags_s, bus1   out 1 each
//  reg_e     out  4  one-hot enable of R0..R3 onto the bus
//  reg_s     out  4  one-hot set of R0..R3
//  alu_op    out  3  ALU opcode; 000 (ADD) unless an ALU instruction is in step 5
// BEHAVIOUR
//  - Reset (async): state = IDLE; step = 0; halted = 1. All controls are 0 and are deasserted
//    combinationally as soon as reset_n falls.
//  - IDLE -> S1 on a clk edge with run = 1. S1..S6 each advance to the next step every cycle.
//  - S7 -> S1 if run = 1 and no IO halt is pending; otherwise S7 -> IDLE.
//  - run = 0 mid-instruction never aborts it; the instruction completes through S7.
//  - Controls are pure decode of (step, ir, flags_in), so each control is level for its whole step.
//    A destination register captures at the end of the cycle in which its *_s signal is 1.
//  - Fetch, identical for all opcodes:
//    S1: bus1, iar_e, mar_s, acc_s
//    S2: ram_e, ir_s
//    S3: acc_e, iar_s
//  - Decode fields: ra = ir[3:2], rb = ir[1:0]. ir[7] = 1 selects ALU, with op = ir[6:4].
//  - Execute (S4 / S5 / S6; "-" means no controls asserted):
//    ALU   reg_e[rb], tmp_s / reg_e[ra], alu_op = op, acc_s, flags_s / acc_e, reg_s[rb]
//          (for op = 111 CMP, S6 is "-")
//    0000 LD     reg_e[ra], mar_s / ram_e, reg_s[rb] / -
//    0001 ST     reg_e[ra], mar_s / reg_e[rb], ram_s / -
//    0010 DATA   bus1, iar_e, mar_s, acc_s / ram_e, reg_s[rb] / acc_e, iar_s
//    0011 JMPR   reg_e[rb], iar_s / - / -
//    0100 JMP    iar_e, mar_s / ram_e, iar_s / -
//    0101 JMPIF  bus1, iar_e, mar_s, acc_s / acc_e, iar_s / ram_e, iar_s only if |(flags_in & ir[3:0])
//    0110 CLF    bus1, flags_s / - / -
//    0111 IO     - / - / -   (with HALT_ON_IO = 1, a halt is latched in S4 and taken at the end of S7)
//  - S7: no controls asserted.
//  - Invariants, checked by assertion:
//    at most one bus driver per cycle (iar_e, ram_e, acc_e, reg_e bits);
//    reg_e and reg_s are each one-hot or zero;
//    no *_s signal is asserted in IDLE or S7.
//  - flags_in is sampled only in S6 of JMPIF; ir is used only in S4..S6.
// STRUCTURE
//  - Shared include cpu_defs.vh holds:
//    opcode localparams (OP_LD..OP_IO, ALU_ADD..ALU_CMP);
//    flag bit indices (FLG_C/A/E/Z);
//    step indices.
//  - Sub-module stepper: ring counter plus IDLE state, with inputs run and halt_req and outputs step and halted.
//  - control_sequencer holds the stepper and the combinational decode.
// TESTING
//  1. Reset and start: reset_n = 0 -> all outputs 0, halted = 1.
//     Release, run = 1 -> next edge step = 7'b0000001 with iar_e, bus1, mar_s, acc_s = 1.
//     Following edge -> ram_e = 1, ir_s = 1.
//  2. ALU, ir = 8'h81 (ADD R0,R1):
//     S4: reg_e = 4'b0010, tmp_s.
//     S5: reg_e = 4'b0001, alu_op = 000, acc_s, flags_s.
//     S6: acc_e, reg_s = 4'b0010.
//     ir = 8'hF6 (CMP) -> S6 all controls 0.
//  3. JMPIF, ir = 8'h52 (jump if E):
//     flags_in = 4'b0010 -> S6 ram_e = 1, iar_s = 1.
//     flags_in = 4'b0101 -> S6 all controls 0.
//  4. DATA, ir = 8'h22 (rb = 2):
//     S4: bus1, iar_e, mar_s, acc_s.
//     S5: ram_e, reg_s = 4'b0100.
//     S6: acc_e, iar_s.
//     The same instruction run back-to-back must show continuous S1..S7 cycling.
//  5. run dropped in S3 -> sequence continues S4..S7, then IDLE with halted = 1.
//     reset_n pulsed low in S5 -> step = 0 and all controls 0 immediately, without waiting for a clk edge.
//  6. HALT_ON_IO = 1, ir = 8'h70, run held at 1 -> IDLE after S7.
//     With HALT_ON_IO = 0, the same stimulus -> S1 follows S7.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the 8-bit CPU control sequencer: instruction
//   opcodes, ALU operation codes, flag bit positions, step indices, the
//   stepper state type and a register-select helper.
package control_sequencer_pkg;

  // Non-ALU opcodes (ir[7] = 0, value of ir[7:4])
  localparam logic [3:0] OP_LD    = 4'h0;
  localparam logic [3:0] OP_ST    = 4'h1;
  localparam logic [3:0] OP_DATA  = 4'h2;
  localparam logic [3:0] OP_JMPR  = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_JMPIF = 4'h5;
  localparam logic [3:0] OP_CLF   = 4'h6;
  localparam logic [3:0] OP_IO    = 4'h7;

  // ALU operations (ir[6:4] when ir[7] = 1)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SHR = 3'd1;
  localparam logic [2:0] ALU_SHL = 3'd2;
  localparam logic [2:0] ALU_NOT = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  // Bit positions inside flags_in = {C,A,E,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_E = 1;
  localparam int FLG_A = 2;
  localparam int FLG_C = 3;

  // Bit index of each step inside the one-hot step vector
  localparam int STEP_1    = 0;
  localparam int STEP_2    = 1;
  localparam int STEP_3    = 2;
  localparam int STEP_4    = 3;
  localparam int STEP_5    = 4;
  localparam int STEP_6    = 5;
  localparam int STEP_7    = 6;
  localparam int NUM_STEPS = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // One-hot select of R0..R3 from a 2-bit register field
  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    reg_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_stepper.sv
// control_sequencer_stepper
//   Seven-step ring counter with an IDLE state. Leaves IDLE when run is
//   seen; steps 1..6 always advance; step 7 wraps to step 1 when run is
//   high and no halt is requested, otherwise returns to IDLE.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   run          : continue fetching
//   halt_req     : stop after the current step 7
//   step         : one-hot current step (bit0 = step 1), 0 in IDLE
//   halted       : high while in IDLE
module control_sequencer_stepper
  import control_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 halt_req,
  output logic [NUM_STEPS-1:0] step,
  output logic                 halted
);

  seq_state_e           state_q, state_d;
  logic [NUM_STEPS-1:0] ring_q, ring_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ring_q  <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          ring_d  = NUM_STEPS'(1);
        end
      end
      ST_RUN: begin
        if (ring_q[STEP_7]) begin
          if (run && !halt_req) begin
            ring_d = NUM_STEPS'(1);
          end else begin
            state_d = ST_IDLE;
            ring_d  = '0;
          end
        end else begin
          ring_d = {ring_q[NUM_STEPS-2:0], 1'b0};
        end
      end
    endcase
  end

  assign step   = ring_q;
  assign halted = (state_q == ST_IDLE);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Stepper plus instruction decoder for the 8-bit CPU. Steps 1-3 fetch the
//   next instruction into the IR, steps 4-6 execute it, step 7 is idle.
//   All datapath controls are a pure decode of (step, ir, flags_in).
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   run                 : keep fetching (sampled in IDLE and at end of step 7)
//   ir                  : instruction register contents
//   flags_in            : {C,A,E,Z}
//   step, halted        : one-hot step (0 in IDLE), IDLE indicator
//   *_e / *_s / bus1    : bus enables, register sets, bus1 forcing
//   reg_e, reg_s        : one-hot enable / set of R0..R3
//   alu_op              : ALU operation, ADD when not executing an ALU op
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int HALT_ON_IO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [7:0] ir,
  input  logic [3:0] flags_in,
  output logic [6:0] step,
  output logic       halted,
  output logic       ir_s,
  output logic       iar_e,
  output logic       iar_s,
  output logic       mar_s,
  output logic       ram_e,
  output logic       ram_s,
  output logic       acc_e,
  output logic       acc_s,
  output logic       tmp_s,
  output logic       flags_s,
  output logic       bus1,
  output logic [3:0] reg_e,
  output logic [3:0] reg_s,
  output logic [2:0] alu_op
);

  logic       halt_pending;
  logic       is_alu;
  logic [3:0] opcode;
  logic [2:0] op;
  logic [3:0] ra_sel, rb_sel;
  logic       jump_taken;

  assign is_alu     = ir[7];
  assign opcode     = ir[7:4];
  assign op         = ir[6:4];
  assign ra_sel     = reg_onehot(ir[3:2]);
  assign rb_sel     = reg_onehot(ir[1:0]);
  assign jump_taken = |(flags_in & ir[3:0]);

  control_sequencer_stepper u_stepper (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .halt_req (halt_pending),
    .step     (step),
    .halted   (halted)
  );

  // An IO instruction arms the halt while it executes; the stepper acts on
  // it at the end of step 7, after which it is cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_pending <= 1'b0;
    end else if (step[STEP_4] && !is_alu && (opcode == OP_IO) && (HALT_ON_IO != 0)) begin
      halt_pending <= 1'b1;
    end else if (step[STEP_7]) begin
      halt_pending <= 1'b0;
    end
  end

  always_comb begin
    ir_s    = 1'b0;
    iar_e   = 1'b0;
    iar_s   = 1'b0;
    mar_s   = 1'b0;
    ram_e   = 1'b0;
    ram_s   = 1'b0;
    acc_e   = 1'b0;
    acc_s   = 1'b0;
    tmp_s   = 1'b0;
    flags_s = 1'b0;
    bus1    = 1'b0;
    reg_e   = '0;
    reg_s   = '0;
    alu_op  = ALU_ADD;

    if (step[STEP_1]) begin
      // IAR -> MAR, IAR+1 -> ACC
      bus1  = 1'b1;
      iar_e = 1'b1;
      mar_s = 1'b1;
      acc_s = 1'b1;
    end else if (step[STEP_2]) begin
      ram_e = 1'b1;
      ir_s  = 1'b1;
    end else if (step[STEP_3]) begin
      acc_e = 1'b1;
      iar_s = 1'b1;
    end else if (step[STEP_4]) begin
      if (is_alu) begin
        reg_e = rb_sel;
        tmp_s = 1'b1;
      end else begin
        case (opcode)
          OP_LD, OP_ST: begin
            reg_e = ra_sel;
            mar_s = 1'b1;
          end
          OP_DATA, OP_JMPIF: begin
            bus1  = 1'b1;
            iar_e = 1'b1;
            mar_s = 1'b1;
            acc_s = 1'b1;
          end
          OP_JMPR: begin
            reg_e = rb_sel;
            iar_s = 1'b1;
          end
          OP_JMP: begin
            iar_e = 1'b1;
            mar_s = 1'b1;
          end
          OP_CLF: begin
            bus1    = 1'b1;
            flags_s = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (step[STEP_5]) begin
      if (is_alu) begin
        reg_e   = ra_sel;
        alu_op  = op;
        acc_s   = 1'b1;
        flags_s = 1'b1;
      end else begin
        case (opcode)
          OP_LD: begin
            ram_e = 1'b1;
            reg_s = rb_sel;
          end
          OP_ST: begin
            reg_e = rb_sel;
            ram_s = 1'b1;
          end
          OP_DATA: begin
            ram_e = 1'b1;
            reg_s = rb_sel;
          end
          OP_JMP: begin
            ram_e = 1'b1;
            iar_s = 1'b1;
          end
          OP_JMPIF: begin
            // Default path: skip the address byte
            acc_e = 1'b1;
            iar_s = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (step[STEP_6]) begin
      if (is_alu) begin
        // CMP only updates flags; the result is discarded
        if (op != ALU_CMP) begin
          acc_e = 1'b1;
          reg_s = rb_sel;
        end
      end else begin
        case (opcode)
          OP_DATA: begin
            acc_e = 1'b1;
            iar_s = 1'b1;
          end
          OP_JMPIF: begin
            // MAR still holds the address byte loaded in step 4
            if (jump_taken) begin
              ram_e = 1'b1;
              iar_s = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  a_one_driver: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({iar_e, ram_e, acc_e, reg_e}));

  a_reg_e_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(reg_e));

  a_reg_s_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(reg_s));

  a_no_set_when_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (halted || step[STEP_7]) |->
      !(ir_s || iar_s || mar_s || ram_s || acc_s || tmp_s || flags_s || (|reg_s)));

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       run = 1'b0;
  logic [7:0] ir = 8'h00;
  logic [3:0] flags_in = 4'h0;

  // Instance A: HALT_ON_IO = 0
  logic [6:0] step_a;
  logic       halted_a, ir_s_a, iar_e_a, iar_s_a, mar_s_a, ram_e_a, ram_s_a;
  logic       acc_e_a, acc_s_a, tmp_s_a, flags_s_a, bus1_a;
  logic [3:0] reg_e_a, reg_s_a;
  logic [2:0] alu_op_a;
  // Instance B: HALT_ON_IO = 1
  logic [6:0] step_b;
  logic       halted_b, ir_s_b, iar_e_b, iar_s_b, mar_s_b, ram_e_b, ram_s_b;
  logic       acc_e_b, acc_s_b, tmp_s_b, flags_s_b, bus1_b;
  logic [3:0] reg_e_b, reg_s_b;
  logic [2:0] alu_op_b;

  control_sequencer #(.HALT_ON_IO(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .flags_in(flags_in),
    .step(step_a), .halted(halted_a), .ir_s(ir_s_a), .iar_e(iar_e_a),
    .iar_s(iar_s_a), .mar_s(mar_s_a), .ram_e(ram_e_a), .ram_s(ram_s_a),
    .acc_e(acc_e_a), .acc_s(acc_s_a), .tmp_s(tmp_s_a), .flags_s(flags_s_a),
    .bus1(bus1_a), .reg_e(reg_e_a), .reg_s(reg_s_a), .alu_op(alu_op_a)
  );

  control_sequencer #(.HALT_ON_IO(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .flags_in(flags_in),
    .step(step_b), .halted(halted_b), .ir_s(ir_s_b), .iar_e(iar_e_b),
    .iar_s(iar_s_b), .mar_s(mar_s_b), .ram_e(ram_e_b), .ram_s(ram_s_b),
    .acc_e(acc_e_b), .acc_s(acc_s_b), .tmp_s(tmp_s_b), .flags_s(flags_s_b),
    .bus1(bus1_b), .reg_e(reg_e_b), .reg_s(reg_s_b), .alu_op(alu_op_b)
  );

  always #5 clk = ~clk;

  // Control word layout: {ir_s,iar_e,iar_s,mar_s,ram_e,ram_s,acc_e,acc_s,
  //                       tmp_s,flags_s,bus1,reg_e[3:0],reg_s[3:0],alu_op[2:0]}
  logic [21:0] ctl_a, ctl_b;
  assign ctl_a = {ir_s_a, iar_e_a, iar_s_a, mar_s_a, ram_e_a, ram_s_a, acc_e_a, acc_s_a,
                  tmp_s_a, flags_s_a, bus1_a, reg_e_a, reg_s_a, alu_op_a};
  assign ctl_b = {ir_s_b, iar_e_b, iar_s_b, mar_s_b, ram_e_b, ram_s_b, acc_e_b, acc_s_b,
                  tmp_s_b, flags_s_b, bus1_b, reg_e_b, reg_s_b, alu_op_b};

  localparam logic [21:0] M_IR_S    = 22'h200000;
  localparam logic [21:0] M_IAR_E   = 22'h100000;
  localparam logic [21:0] M_IAR_S   = 22'h080000;
  localparam logic [21:0] M_MAR_S   = 22'h040000;
  localparam logic [21:0] M_RAM_E   = 22'h020000;
  localparam logic [21:0] M_RAM_S   = 22'h010000;
  localparam logic [21:0] M_ACC_E   = 22'h008000;
  localparam logic [21:0] M_ACC_S   = 22'h004000;
  localparam logic [21:0] M_TMP_S   = 22'h002000;
  localparam logic [21:0] M_FLAGS_S = 22'h001000;
  localparam logic [21:0] M_BUS1    = 22'h000800;
  localparam logic [21:0] M_FETCH   = M_BUS1 | M_IAR_E | M_MAR_S | M_ACC_S;

  function automatic logic [21:0] re(input int n);
    return 22'(1) << (7 + n);
  endfunction
  function automatic logic [21:0] rs(input int n);
    return 22'(1) << (3 + n);
  endfunction
  function automatic logic [21:0] aop(input int op);
    return 22'(op);
  endfunction

  // Reference: controls expected for step number s (0 = IDLE, 1..7)
  function automatic logic [21:0] model_ctl(input int s, input logic [7:0] i, input logic [3:0] f);
    logic [21:0] ex [3];
    int ra;
    int rb;
    int op;
    ra = int'(i[3:2]);
    rb = int'(i[1:0]);
    op = int'(i[6:4]);
    if (s == 1) return M_FETCH;
    if (s == 2) return M_RAM_E | M_IR_S;
    if (s == 3) return M_ACC_E | M_IAR_S;
    if (s < 4 || s > 6) return '0;
    if (i[7]) begin
      ex = '{re(rb) | M_TMP_S,
             re(ra) | aop(op) | M_ACC_S | M_FLAGS_S,
             (op == 7) ? 22'(0) : (M_ACC_E | rs(rb))};
    end else begin
      case (op)
        0: ex = '{re(ra) | M_MAR_S, M_RAM_E | rs(rb), 22'(0)};
        1: ex = '{re(ra) | M_MAR_S, re(rb) | M_RAM_S, 22'(0)};
        2: ex = '{M_FETCH, M_RAM_E | rs(rb), M_ACC_E | M_IAR_S};
        3: ex = '{re(rb) | M_IAR_S, 22'(0), 22'(0)};
        4: ex = '{M_IAR_E | M_MAR_S, M_RAM_E | M_IAR_S, 22'(0)};
        5: ex = '{M_FETCH, M_ACC_E | M_IAR_S, ((f & i[3:0]) != 0) ? (M_RAM_E | M_IAR_S) : 22'(0)};
        6: ex = '{M_BUS1 | M_FLAGS_S, 22'(0), 22'(0)};
        default: ex = '{22'(0), 22'(0), 22'(0)};
      endcase
    end
    return ex[s - 4];
  endfunction

  function automatic int nxt(input int s, input bit r, input bit hp);
    if (s == 0) return r ? 1 : 0;
    if (s < 7) return s + 1;
    return (r && !hp) ? 1 : 0;
  endfunction

  function automatic logic [6:0] exp_step(input int s);
    return (s == 0) ? 7'd0 : (7'(1) << (s - 1));
  endfunction

  int ms_a = 0;
  int ms_b = 0;
  bit hp_b = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check(input string nm);
    #1;
    cmp({nm, "_a"}, {step_a, halted_a, ctl_a},
        {exp_step(ms_a), (ms_a == 0), model_ctl(ms_a, ir, flags_in)});
    cmp({nm, "_b"}, {step_b, halted_b, ctl_b},
        {exp_step(ms_b), (ms_b == 0), model_ctl(ms_b, ir, flags_in)});
  endtask

  task automatic cycle();
    int na;
    int nb;
    bit nhp;
    na  = nxt(ms_a, run, 1'b0);
    nb  = nxt(ms_b, run, hp_b);
    nhp = hp_b;
    if (ms_b == 4 && ir[7:4] == 4'h7) nhp = 1'b1;
    else if (ms_b == 7) nhp = 1'b0;
    @(posedge clk);
    #1;
    ms_a = na;
    ms_b = nb;
    hp_b = nhp;
  endtask

  task automatic wait_step_a(input int s, input string nm);
    for (int g = 0; g < 20 && ms_a != s; g++) begin
      cycle();
      check(nm);
    end
    cmp({nm, "_reached"}, step_a, exp_step(s));
  endtask

  typedef struct {
    logic [7:0]  ir;
    logic [3:0]  fl;
    logic [21:0] e4;
    logic [21:0] e5;
    logic [21:0] e6;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1);
  end

  initial begin
    tbl.push_back('{8'h81, 4'h0, re(1) | M_TMP_S, re(0) | M_ACC_S | M_FLAGS_S, M_ACC_E | rs(1)});
    tbl.push_back('{8'hF6, 4'h0, re(2) | M_TMP_S, re(1) | aop(7) | M_ACC_S | M_FLAGS_S, 22'(0)});
    tbl.push_back('{8'hA4, 4'h0, re(0) | M_TMP_S, re(1) | aop(2) | M_ACC_S | M_FLAGS_S, M_ACC_E | rs(0)});
    tbl.push_back('{8'h52, 4'b0010, M_FETCH, M_ACC_E | M_IAR_S, M_RAM_E | M_IAR_S});
    tbl.push_back('{8'h52, 4'b0101, M_FETCH, M_ACC_E | M_IAR_S, 22'(0)});
    tbl.push_back('{8'h58, 4'b1000, M_FETCH, M_ACC_E | M_IAR_S, M_RAM_E | M_IAR_S});
    tbl.push_back('{8'h22, 4'h0, M_FETCH, M_RAM_E | rs(2), M_ACC_E | M_IAR_S});
    tbl.push_back('{8'h0D, 4'h0, re(3) | M_MAR_S, M_RAM_E | rs(1), 22'(0)});
    tbl.push_back('{8'h16, 4'h0, re(1) | M_MAR_S, re(2) | M_RAM_S, 22'(0)});
    tbl.push_back('{8'h33, 4'h0, re(3) | M_IAR_S, 22'(0), 22'(0)});
    tbl.push_back('{8'h40, 4'h0, M_IAR_E | M_MAR_S, M_RAM_E | M_IAR_S, 22'(0)});
    tbl.push_back('{8'h60, 4'h0, M_BUS1 | M_FLAGS_S, 22'(0), 22'(0)});
    tbl.push_back('{8'h70, 4'h0, 22'(0), 22'(0), 22'(0)});

    // Reset and start
    #2;
    reset_n = 1'b0;
    check("reset");
    cmp("reset_halted", {halted_a, halted_b}, 2'b11);
    @(negedge clk);
    reset_n = 1'b1;
    run = 1'b1;
    check("idle_run");
    cycle();
    check("start_s1");
    cmp("start_s1_ctl", {step_a, iar_e_a, bus1_a, mar_s_a, acc_s_a}, {7'b0000001, 4'b1111});
    cycle();
    check("start_s2");
    cmp("start_s2_ctl", {ram_e_a, ir_s_a}, 2'b11);

    // Per-instruction vectors, execute steps compared against the table
    foreach (tbl[k]) begin
      ir = tbl[k].ir;
      flags_in = tbl[k].fl;
      check("tbl_set");
      wait_step_a(4, "tbl_wait");
      cmp($sformatf("tbl%0d_s4", k), ctl_a, tbl[k].e4);
      cycle();
      check("tbl_s5");
      cmp($sformatf("tbl%0d_s5", k), ctl_a, tbl[k].e5);
      cycle();
      check("tbl_s6");
      cmp($sformatf("tbl%0d_s6", k), ctl_a, tbl[k].e6);
    end

    // DATA back-to-back: continuous S1..S7 cycling
    ir = 8'h22;
    flags_in = 4'h0;
    check("b2b_set");
    wait_step_a(7, "b2b_wait");
    for (int k = 0; k < 14; k++) begin
      cycle();
      check("b2b");
      cmp("b2b_step", step_a, 7'(1) << (k % 7));
    end

    // run dropped in step 3: instruction completes, then IDLE
    wait_step_a(3, "drop_wait");
    run = 1'b0;
    check("drop_s3");
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("drop_tail");
    end
    cmp("drop_s7", step_a, 7'b1000000);
    cycle();
    check("drop_idle");
    cmp("drop_idle_halted", {step_a, halted_a}, {7'd0, 1'b1});
    cycle();
    check("drop_stay_idle");

    // Asynchronous reset in step 5
    run = 1'b1;
    ir = 8'h81;
    wait_step_a(5, "rst_wait");
    #1;
    reset_n = 1'b0;
    #1;
    cmp("async_rst_a", {step_a, halted_a, ctl_a}, {7'd0, 1'b1, 22'd0});
    cmp("async_rst_b", {step_b, halted_b, ctl_b}, {7'd0, 1'b1, 22'd0});
    ms_a = 0;
    ms_b = 0;
    hp_b = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run = 1'b0;
    check("post_rst");

    // IO with run held: B halts after S7, A continues into S1
    ir = 8'h70;
    run = 1'b1;
    check("io_set");
    wait_step_a(7, "io_wait");
    cmp("io_b_s7", step_b, 7'b1000000);
    cycle();
    check("io_after");
    cmp("io_halt_b", {step_b, halted_b}, {7'd0, 1'b1});
    cmp("io_cont_a", {step_a, halted_a}, {7'b0000001, 1'b0});
    cycle();
    check("io_restart");

    // Randomized run against the reference model
    for (int k = 0; k < 500; k++) begin
      ir = 8'($urandom);
      flags_in = 4'($urandom);
      run = ($urandom_range(0, 9) != 0);
      check("rand");
      cycle();
    end
    check("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
